// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : FSM states, digit-correction constant and digit-count sizing helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ = 4'd3;

  // ceil(bin_w * log10(2)) with log10(2) held as 0.30103 in fixed point
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_add3_cell : one-digit double-dabble correction (d >= 5 ? d + 3 : d)
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + BCD_ADJ) : din;

endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seq_converter : bit-serial binary-to-BCD converter with valid/ready I/O
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter  int BIN_W  = 8,
  parameter  int DIGITS = 3,
  localparam int ND_W   = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      binary_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [ND_W-1:0]       ndigits,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $error("bcd_seq_converter: DIGITS too small for BIN_W");
  end

  bcd_state_t            state, state_next;
  logic [BIN_W-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   bcd_acc;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_shifted;
  logic [CNT_W-1:0]      cnt;
  logic [ND_W-1:0]       nd_reg;
  logic [ND_W-1:0]       nd_next;
  logic                  load;
  logic                  last_shift;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_cell u_cell (
      .din  (bcd_acc[4*k +: 4]),
      .dout (bcd_adj[4*k +: 4])
    );
  end

  // Corrected digits shift left, pulling in the next binary MSB
  assign bcd_shifted = {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};

  always_comb begin
    nd_next = ND_W'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (bcd_shifted[4*k +: 4] != 4'd0) nd_next = ND_W'(k + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    load       = 1'b0;
    last_shift = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          last_shift = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      nd_reg  <= ND_W'(1);
    end else if (load) begin
      bin_sr  <= binary_in;
      bcd_acc <= '0;
      cnt     <= CNT_W'(BIN_W);
    end else if (state == SHIFT) begin
      bin_sr  <= bin_sr << 1;
      bcd_acc <= bcd_shifted;
      cnt     <= cnt - CNT_W'(1);
      if (last_shift) nd_reg <= nd_next;
    end
  end

  assign bcd_out = bcd_acc;
  assign ndigits = nd_reg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_seq_converter : self-checking bench for 8-bit/3-digit and 16-bit/5-digit builds
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [7:0]  a_bin = '0;
  logic [11:0] a_bcd;
  logic [1:0]  a_nd;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [15:0] b_bin = '0;
  logic [19:0] b_bcd;
  logic [2:0]  b_nd;

  int n_checks = 0;
  int n_pass   = 0;
  int ops_q[$];

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .binary_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd_out(a_bcd), .ndigits(a_nd), .busy(a_busy)
  );

  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .binary_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd_out(b_bcd), .ndigits(b_nd), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Decimal digits by repeated division, one nibble per digit
  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input int v);
    int n = 1;
    int x = v;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand to DUT A, return cycles from accepting edge to out_valid
  task automatic send_a(input int v, output int lat);
    int w = 0;
    lat = -1;
    while (!a_in_ready && w < 50) begin tick(); w++; end
    a_in_valid = 1'b1;
    a_bin      = 8'(v);
    tick();
    a_in_valid = 1'b0;
    a_bin      = 8'($urandom);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_out_valid) begin lat = i; break; end
    end
  endtask

  task automatic send_b(input int v, output int lat);
    int w = 0;
    lat = -1;
    while (!b_in_ready && w < 50) begin tick(); w++; end
    b_in_valid = 1'b1;
    b_bin      = 16'(v);
    tick();
    b_in_valid = 1'b0;
    b_bin      = 16'($urandom);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (b_out_valid) begin lat = i; break; end
    end
  endtask

  // Streams ops_q through DUT A with continuous in_valid, scoreboarding every result
  task automatic run_stream(input bit rand_stall, input bit check_gap);
    int n = ops_q.size();
    int sent = 0, got = 0, cyc = 0, last = -1;
    int exp_q[$];
    bit acc, ret, prev_ov;
    int v;
    prev_ov = a_out_valid;
    while (got < n && cyc < 20 * n + 100) begin
      if (check_gap && a_out_valid && !prev_ov) begin
        if (last >= 0) check("result_gap", cyc - last, 10);
        last = cyc;
      end
      prev_ov     = a_out_valid;
      a_out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      a_in_valid  = (sent < n);
      a_bin       = (sent < n) ? 8'(ops_q[sent]) : 8'($urandom);
      acc = a_in_valid && a_in_ready;
      ret = a_out_valid && a_out_ready;
      if (ret) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          v = exp_q.pop_front();
          check($sformatf("bcd[%0d]", v), a_bcd, ref_bcd(v));
          check($sformatf("nd[%0d]", v), a_nd, ref_nd(v));
        end
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(ops_q[sent]);
        sent++;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    check("stream_count", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ov_cnt, busy_cnt;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_nd", a_nd, 1);
    rst = 1'b0;
    tick();

    // Zero operand
    send_a(0, lat);
    check("lat_zero", lat, 8);
    check("bcd_zero", a_bcd, 0);
    check("nd_zero", a_nd, 1);
    check("busy_done", a_busy, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Back-to-back operands, full throughput
    ops_q = '{255, 128, 14};
    run_stream(1'b0, 1'b1);
    tick();

    // Backpressure: result held, extra operand ignored
    send_a(99, lat);
    check("lat_99", lat, 8);
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'b1;
      a_bin      = 8'd5;
      check("hold_out_valid", a_out_valid, 1);
      check("hold_bcd", a_bcd, 12'h099);
      check("hold_in_ready", a_in_ready, 0);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("release_out_valid", a_out_valid, 0);
    check("release_in_ready", a_in_ready, 1);
    check("release_bcd", a_bcd, 12'h099);

    // Reset during SHIFT, with in_valid held high throughout reset
    a_in_valid = 1'b1;
    a_bin      = 8'd200;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    check("mid_busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", a_in_ready, 1);
    check("abort_out_valid", a_out_valid, 0);
    check("abort_busy", a_busy, 0);
    check("abort_bcd", a_bcd, 0);
    check("abort_nd", a_nd, 1);
    a_in_valid = 1'b1;
    a_bin      = 8'd77;
    repeat (2) tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    ov_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_out_valid) ov_cnt++;
      if (a_busy) busy_cnt++;
    end
    check("post_abort_out_valid", ov_cnt, 0);
    check("post_abort_busy", busy_cnt, 0);

    // Wide build
    send_b(65535, lat);
    check("b_lat_65535", lat, 16);
    check("b_bcd_65535", b_bcd, ref_bcd(65535));
    check("b_nd_65535", b_nd, 5);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    send_b(1000, lat);
    check("b_lat_1000", lat, 16);
    check("b_bcd_1000", b_bcd, 20'h01000);
    check("b_nd_1000", b_nd, 4);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    // Every 8-bit value with random consumer stalls
    ops_q.delete();
    for (int v = 0; v < 256; v++) ops_q.push_back(v);
    run_stream(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
